// File: rtl/pipe_stage_latch.sv
// Pipeline stage register with a valid/ready handshake, flush-to-bubble, an optional
// 2-entry skid buffer and a saturating back-pressure counter.
module pipe_stage_latch #(
    parameter int CTRL_W      = 8,
    parameter int DATA_W      = 160,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [CTRL_W-1:0]      in_ctrl_i,
    input  logic [DATA_W-1:0]      in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [CTRL_W-1:0]      out_ctrl_o,
    output logic [DATA_W-1:0]      out_data_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    logic                   main_vld_q, main_vld_d;
    logic [CTRL_W-1:0]      main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]      main_data_q, main_data_d;
    logic                   skid_vld_q, skid_vld_d;
    logic [CTRL_W-1:0]      skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]      skid_data_q, skid_data_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   accept, consume;

    // With the skid buffer, ready depends only on a flop (skid occupancy), so the
    // downstream stall never ripples combinationally to upstream.
    assign in_ready_o  = rst_n & ((SKID != 0) ? ~skid_vld_q : (~main_vld_q | out_ready_i));
    assign accept      = in_valid_i & in_ready_o & ~flush_i;
    assign consume     = main_vld_q & out_ready_i;

    assign out_valid_o = main_vld_q;
    assign out_ctrl_o  = main_ctrl_q & {CTRL_W{main_vld_q}};
    assign out_data_o  = main_data_q;
    assign stall_cnt_o = stall_q;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        stall_d     = stall_q;

        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (consume) begin
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_vld_d  = 1'b0;
            end
        end else if (accept && main_vld_q && !consume) begin
            // Only reachable with SKID=1: main is blocked, park the beat in the skid slot.
            skid_ctrl_d = in_ctrl_i;
            skid_data_d = in_data_i;
            skid_vld_d  = 1'b1;
        end else if (accept) begin
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
            main_vld_d  = 1'b1;
        end else if (consume) begin
            main_vld_d = 1'b0;
        end

        if (main_vld_q && !out_ready_i && !(&stall_q))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: a SKID=1 instance (4-bit stall counter) and a SKID=0
// instance share stimulus tasks; a queue-based reference tracks contents of each stage.
module tb_pipe_stage_latch;
    localparam int CW = 8;
    localparam int DW = 32;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]         flush, iv, ordy, irdy, ov;
    logic [1:0][CW-1:0] ictl, octl;
    logic [1:0][DW-1:0] idat, odat;
    logic [3:0]         st0;
    logic [15:0]        st1;

    always #5 clk = ~clk;

    pipe_stage_latch #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .STALL_CNT_W(4)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[0]),
        .in_valid_i(iv[0]), .in_ready_o(irdy[0]), .in_ctrl_i(ictl[0]), .in_data_i(idat[0]),
        .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .out_ctrl_o(octl[0]), .out_data_o(odat[0]),
        .stall_cnt_o(st0));

    pipe_stage_latch #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .STALL_CNT_W(16)) u_noskid (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[1]),
        .in_valid_i(iv[1]), .in_ready_o(irdy[1]), .in_ctrl_i(ictl[1]), .in_data_i(idat[1]),
        .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .out_ctrl_o(octl[1]), .out_data_o(odat[1]),
        .stall_cnt_o(st1));

    beat_t sbq [2][$];
    int    exp_st [2];
    bit    rdy_m [2];
    bit    chk_en = 1'b0;
    int    nchk = 0;
    int    nerr = 0;

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the reference and retires consumed beats.
    always @(negedge clk) begin
        #3;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [63:0] ast;
                bit          ev;
                beat_t       fr;
                ev  = sbq[k].size() != 0;
                ast = (k == 0) ? 64'(st0) : 64'(st1);
                chk("in_ready", k, 64'(irdy[k]), 64'(rdy_m[k]));
                chk("out_valid", k, 64'(ov[k]), 64'(ev));
                chk("stall_cnt", k, ast, 64'(exp_st[k]));
                if (!ov[k]) begin
                    chk("bubble_ctrl", k, 64'(octl[k]), 64'd0);
                end else if (ev) begin
                    fr = sbq[k][0];
                    chk("out_ctrl", k, 64'(octl[k]), 64'(fr.ctrl));
                    chk("out_data", k, 64'(odat[k]), 64'(fr.data));
                    if (ordy[k]) void'(sbq[k].pop_front());
                end
            end
        end
    end

    // Called at a negedge with inputs applied: predicts this edge from the stage
    // contents (capacity 2 with skid, 1 without) and updates the reference after the monitor ran.
    task automatic step();
        bit    acc [2];
        bit    stl [2];
        beat_t b   [2];
        for (int k = 0; k < 2; k++) begin
            if (k == 0) rdy_m[k] = rst_n && (sbq[k].size() < 2);
            else        rdy_m[k] = rst_n && (sbq[k].size() == 0 || ordy[k]);
            acc[k] = iv[k] && rdy_m[k] && !flush[k];
            stl[k] = sbq[k].size() != 0 && !ordy[k];
            b[k]   = '{ctrl: ictl[k], data: idat[k]};
        end
        chk_en = 1'b1;
        #4;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                sbq[k].delete();
                exp_st[k] = 0;
            end else begin
                if (flush[k])    sbq[k].delete();
                else if (acc[k]) sbq[k].push_back(b[k]);
                if (stl[k] && exp_st[k] < ((k == 0) ? 15 : 65535)) exp_st[k]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic f, input logic v, input logic r, input logic [DW-1:0] d);
        flush = {2{f}};
        iv    = {2{v}};
        ordy  = {2{r}};
        for (int k = 0; k < 2; k++) begin
            ictl[k] = CW'($urandom_range(1, 255));
            idat[k] = d;
        end
        step();
    endtask

    initial begin
        exp_st[0] = 0;
        exp_st[1] = 0;
        rst_n = 1'b0;
        flush = '0; iv = '1; ordy = '1; ictl = '0; idat = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset held with in_valid high
        repeat (2) drive(1'b0, 1'b1, 1'b1, 32'hDEAD_0000);
        rst_n = 1'b1;
        // Streaming 1..8
        for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, 1'b1, DW'(i));
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        // Back-pressure: A, B then hold, then drain
        drive(1'b0, 1'b1, 1'b0, 32'hA);
        drive(1'b0, 1'b1, 1'b0, 32'hB);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 32'h0);
        // Flush while full with a new beat offered
        drive(1'b0, 1'b1, 1'b0, 32'hA1);
        drive(1'b0, 1'b1, 1'b0, 32'hB1);
        drive(1'b1, 1'b1, 1'b0, 32'hC1);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        // Saturation of the 4-bit counter, then flush leaves it untouched
        drive(1'b0, 1'b1, 1'b0, 32'h55);
        repeat (20) drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("stall_sat", 0, 64'(st0), 64'hF);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        chk("stall_sat_flush", 0, 64'(st0), 64'hF);
        // Random traffic, independent per instance
        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]    = $urandom_range(0, 3) != 0;
                ordy[k]  = $urandom_range(0, 2) != 0;
                flush[k] = $urandom_range(0, 31) == 0;
                ictl[k]  = CW'($urandom);
                idat[k]  = DW'($urandom);
            end
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
